// File: rtl/cla_addsub_pipe.sv
// Pipelined carry-lookahead adder/subtractor with valid/ready flow control.
// Each stage resolves one WIDTH/STAGES slice from BLOCK-bit lookahead groups.
module cla_addsub_pipe #(
   parameter int WIDTH  = 16,
   parameter int BLOCK  = 4,
   parameter int STAGES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_cin,
   input  logic             in_sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_sum,
   output logic             out_cout,
   output logic             out_ovf,
   output logic             out_gp,
   output logic             out_gg
);
   localparam int SLICE  = WIDTH / STAGES;
   localparam int GROUPS = SLICE / BLOCK;

   // Result layout: {slice generate (cin=0), slice propagate, carry out, sum}
   function automatic logic [SLICE+2:0] slice_add(
      input logic [SLICE-1:0] a,
      input logic [SLICE-1:0] b,
      input logic             cin
   );
      logic [SLICE-1:0] p;
      logic [SLICE-1:0] g;
      logic [SLICE-1:0] s;
      logic             c_grp;
      logic             c_bit;
      logic             g_run;
      logic             p_run;
      logic             gg_grp;
      logic             pp_grp;
      p     = a ^ b;
      g     = a & b;
      s     = {SLICE{1'b0}};
      c_grp = cin;
      g_run = 1'b0;
      p_run = 1'b1;
      for (int j = 0; j < GROUPS; j++) begin
         gg_grp = 1'b0;
         pp_grp = 1'b1;
         c_bit  = c_grp;
         for (int i = 0; i < BLOCK; i++) begin
            s[j*BLOCK+i] = p[j*BLOCK+i] ^ c_bit;
            c_bit        = g[j*BLOCK+i] | (p[j*BLOCK+i] & c_bit);
            gg_grp       = g[j*BLOCK+i] | (p[j*BLOCK+i] & gg_grp);
            pp_grp       = pp_grp & p[j*BLOCK+i];
         end
         // The next group's carry comes from this group's P/G, not its ripple.
         c_grp = gg_grp | (pp_grp & c_grp);
         g_run = gg_grp | (pp_grp & g_run);
         p_run = p_run & pp_grp;
      end
      return {g_run, p_run, c_grp, s};
   endfunction

   logic             valid_q [STAGES];
   logic [WIDTH-1:0] a_q     [STAGES];
   logic [WIDTH-1:0] b_q     [STAGES];
   logic [WIDTH-1:0] sum_q   [STAGES];
   logic             c_q     [STAGES];
   logic             gp_q    [STAGES];
   logic             gg_q    [STAGES];
   logic             ovf_q;

   logic             valid_s [STAGES];
   logic [WIDTH-1:0] a_s     [STAGES];
   logic [WIDTH-1:0] b_s     [STAGES];
   logic [WIDTH-1:0] sum_s   [STAGES];
   logic             c_s     [STAGES];
   logic             gp_s    [STAGES];
   logic             gg_s    [STAGES];
   logic [WIDTH-1:0] sum_d   [STAGES];
   logic             c_d     [STAGES];
   logic             gp_d    [STAGES];
   logic             gg_d    [STAGES];
   logic             ovf_d;
   logic             stall_s;
   logic             ready_s;
   logic [SLICE+2:0] res_s;

   // Stage inputs, per-slice lookahead and the running word-level P/G.
   always_comb begin
      stall_s    = valid_q[STAGES-1] & ~out_ready;
      ready_s    = ~stall_s;
      res_s      = {(SLICE+3){1'b0}};
      valid_s[0] = in_valid & ready_s;
      a_s[0]     = in_a;
      b_s[0]     = in_b ^ {WIDTH{in_sub}};
      sum_s[0]   = {WIDTH{1'b0}};
      c_s[0]     = in_cin ^ in_sub;
      gp_s[0]    = 1'b1;
      gg_s[0]    = 1'b0;
      for (int k = 1; k < STAGES; k++) begin
         valid_s[k] = valid_q[k-1];
         a_s[k]     = a_q[k-1];
         b_s[k]     = b_q[k-1];
         sum_s[k]   = sum_q[k-1];
         c_s[k]     = c_q[k-1];
         gp_s[k]    = gp_q[k-1];
         gg_s[k]    = gg_q[k-1];
      end
      for (int k = 0; k < STAGES; k++) begin
         res_s    = slice_add(a_s[k][k*SLICE +: SLICE], b_s[k][k*SLICE +: SLICE], c_s[k]);
         sum_d[k] = sum_s[k];
         sum_d[k][k*SLICE +: SLICE] = res_s[SLICE-1:0];
         c_d[k]   = res_s[SLICE];
         gp_d[k]  = gp_s[k] & res_s[SLICE+1];
         gg_d[k]  = res_s[SLICE+2] | (res_s[SLICE+1] & gg_s[k]);
      end
      ovf_d = (a_s[STAGES-1][WIDTH-1] == b_s[STAGES-1][WIDTH-1]) &
              (sum_d[STAGES-1][WIDTH-1] != a_s[STAGES-1][WIDTH-1]);
   end

   // Pipeline registers: all stages hold together on stall, data loads only with a valid.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < STAGES; k++) begin
            valid_q[k] <= 1'b0;
            a_q[k]     <= {WIDTH{1'b0}};
            b_q[k]     <= {WIDTH{1'b0}};
            sum_q[k]   <= {WIDTH{1'b0}};
            c_q[k]     <= 1'b0;
            gp_q[k]    <= 1'b0;
            gg_q[k]    <= 1'b0;
         end
         ovf_q <= 1'b0;
      end else if (!stall_s) begin
         for (int k = 0; k < STAGES; k++) begin
            valid_q[k] <= valid_s[k];
            if (valid_s[k]) begin
               a_q[k]   <= a_s[k];
               b_q[k]   <= b_s[k];
               sum_q[k] <= sum_d[k];
               c_q[k]   <= c_d[k];
               gp_q[k]  <= gp_d[k];
               gg_q[k]  <= gg_d[k];
            end
         end
         if (valid_s[STAGES-1]) begin
            ovf_q <= ovf_d;
         end
      end
   end

   assign in_ready  = ready_s;
   assign out_valid = valid_q[STAGES-1];
   assign out_sum   = sum_q[STAGES-1];
   assign out_cout  = c_q[STAGES-1];
   assign out_gp    = gp_q[STAGES-1];
   assign out_gg    = gg_q[STAGES-1];
   assign out_ovf   = ovf_q;

endmodule
